// File: rtl/mul_seq_ctrl.sv
// Multi-cycle sequencer for the RV32M multiply group.
// Drives a shared unsigned multiplier and caches the last product.
module mul_seq_ctrl #(
    parameter int LAT  = 2,
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic              flush,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic [2*XLEN-1:0] mul_p,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   result,
    output logic              busy
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [3:0] CNT_INIT  = 4'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]        r_cnt;
    logic [XLEN-1:0]   r_mul_a;
    logic [XLEN-1:0]   r_mul_b;
    logic              r_neg;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [XLEN-1:0]   r_result;
    logic              r_c_valid;
    logic [XLEN-1:0]   r_c_rs1;
    logic [XLEN-1:0]   r_c_rs2;
    logic [1:0]        r_c_op;
    logic [2*XLEN-1:0] r_c_prod;

    logic              w_accept;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_hit;
    logic [XLEN-1:0]   w_hit_res;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_calc_res;

    assign w_accept = req_valid && (r_state == S_IDLE) && !flush;

    assign w_a_neg = rs1[XLEN-1] && ((op == OP_MULH) || (op == OP_MULHSU));
    assign w_b_neg = rs2[XLEN-1] && (op == OP_MULH);
    assign w_mag_a = w_a_neg ? ({XLEN{1'b0}} - rs1) : rs1;
    assign w_mag_b = w_b_neg ? ({XLEN{1'b0}} - rs2) : rs2;

    // Low word is sign-independent, so MUL hits on any cached class.
    assign w_hit = r_c_valid && (rs1 == r_c_rs1) && (rs2 == r_c_rs2)
                && ((op == OP_MUL) || (op == r_c_op));
    assign w_hit_res = (op == OP_MUL) ? r_c_prod[XLEN-1:0]
                                      : r_c_prod[2*XLEN-1:XLEN];

    assign w_prod = r_neg ? ({(2*XLEN){1'b0}} - mul_p) : mul_p;
    assign w_calc_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0]
                                         : w_prod[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_hit ? S_RESP : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_CALC: begin
                busy = 1'b1;
            end
            S_RESP: begin
                resp_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_neg     <= 1'b0;
            r_op      <= OP_MUL;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_result  <= '0;
            r_c_valid <= 1'b0;
            r_c_rs1   <= '0;
            r_c_rs2   <= '0;
            r_c_op    <= OP_MUL;
            r_c_prod  <= '0;
        end else begin
            if (flush) begin
                r_c_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_hit) begin
                    r_result <= w_hit_res;
                end else begin
                    r_mul_a <= w_mag_a;
                    r_mul_b <= w_mag_b;
                    r_neg   <= w_a_neg ^ w_b_neg;
                    r_op    <= op;
                    r_rs1   <= rs1;
                    r_rs2   <= rs2;
                    r_cnt   <= CNT_INIT;
                end
            end
            if ((r_state == S_CALC) && !flush) begin
                if (r_cnt == 4'd0) begin
                    r_result  <= w_calc_res;
                    r_c_valid <= 1'b1;
                    r_c_rs1   <= r_rs1;
                    r_c_rs2   <= r_rs2;
                    r_c_op    <= r_op;
                    r_c_prod  <= w_prod;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign mul_a  = r_mul_a;
    assign mul_b  = r_mul_b;
    assign result = r_result;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with a behavioural multiplier.
// Expected results go through a queue and are popped on each response.
module tb_mul_seq_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    mul_seq_ctrl #(.LAT(LAT), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .result(result), .busy(busy)
    );

    assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] a64;
        logic [63:0] b64;
        logic [63:0] p;
        a64 = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        b64 = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p = a64 * b64;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output bit tmo);
        @(negedge clk);
        req_valid = 1'b1;
        op = o;
        rs1 = a;
        rs2 = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        tmo = 1'b0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) tmo = 1'b1;
        res = result;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl got rr=%b rv=%b busy=%b want 1 0 0",
                     req_ready, resp_valid, busy);
        end
        checks++;
        if (result !== 32'd0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got res=%h a=%h b=%h want 0",
                     result, mul_a, mul_b);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mulh_cache();
        logic [31:0] r, e;
        int l;
        bit t;
        exp_q.push_back(32'h0000_0000);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e) begin
            failures++;
            $display("FAIL mulh_m1 got %h tmo=%0d want %h", r, t, e);
        end
        checks++;
        if (l !== LAT + 1) begin
            failures++;
            $display("FAIL mulh_lat got %0d want %0d", l, LAT + 1);
        end
        checks++;
        if (mul_a !== 32'd1 || mul_b !== 32'd1) begin
            failures++;
            $display("FAIL mulh_mag got a=%h b=%h want 1 1", mul_a, mul_b);
        end
        exp_q.push_back(32'h0000_0001);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e) begin
            failures++;
            $display("FAIL mul_hit got %h tmo=%0d want %h", r, t, e);
        end
        checks++;
        if (l !== 1) begin
            failures++;
            $display("FAIL hit_lat got %0d want 1", l);
        end
        checks++;
        if (mul_a !== 32'd1) begin
            failures++;
            $display("FAIL hit_ops got a=%h want 1", mul_a);
        end
    endtask

    task automatic test_classes();
        logic [31:0] r, e;
        int l;
        bit t;
        exp_q.push_back(32'hFFFF_FFFE);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e) begin
            failures++;
            $display("FAIL mulhu got %h want %h", r, e);
        end
        exp_q.push_back(32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e) begin
            failures++;
            $display("FAIL mulhsu got %h want %h", r, e);
        end
        checks++;
        if (l !== LAT + 1) begin
            failures++;
            $display("FAIL class_miss_lat got %0d want %0d", l, LAT + 1);
        end
    endtask

    task automatic test_corners();
        logic [31:0] r, e;
        int l;
        bit t;
        exp_q.push_back(32'h4000_0000);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e || mul_a !== 32'h8000_0000) begin
            failures++;
            $display("FAIL mulh_min got %h a=%h want %h", r, mul_a, e);
        end
        exp_q.push_back(32'hFFFF_FFEB);
        run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e || mul_b !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL mul_neg got %h b=%h want %h", r, mul_b, e);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e, held;
        int n;
        exp_q.push_back(model(2'b11, 32'h1234_5678, 32'h9ABC_DEF0));
        @(negedge clk);
        req_valid = 1'b1;
        op = 2'b11;
        rs1 = 32'h1234_5678;
        rs2 = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = exp_q.pop_front();
        held = result;
        checks++;
        if (!resp_valid || held !== e) begin
            failures++;
            $display("FAIL bp_result got %h rv=%b want %h", held, resp_valid, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (resp_valid !== 1'b1 || result !== e || busy !== 1'b1
                || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got rv=%b res=%h busy=%b rr=%b",
                         i, resp_valid, result, busy, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got rv=%b rr=%b busy=%b want 0 1 0",
                     resp_valid, req_ready, busy);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r, e;
        int l;
        bit t;
        bit seen;
        exp_q.push_back(32'd30);
        run_op(2'b00, 32'd5, 32'd6, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e) begin
            failures++;
            $display("FAIL fl_prime got %h want %h", r, e);
        end
        @(negedge clk);
        req_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL fl_idle got busy=%b rv=%b want 0 0", busy, resp_valid);
        end
        exp_q.push_back(32'd30);
        run_op(2'b00, 32'd5, 32'd6, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e || l !== LAT + 1) begin
            failures++;
            $display("FAIL fl_inval got %h lat=%0d want %h lat=%0d",
                     r, l, e, LAT + 1);
        end
        @(negedge clk);
        req_valid = 1'b1;
        op = 2'b00;
        rs1 = 32'd9;
        rs2 = 32'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        seen = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL fl_calc got busy=%b rr=%b want 0 1", busy, req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL fl_noresp got resp_valid=1 want 0");
        end
        exp_q.push_back(32'd81);
        run_op(2'b00, 32'd9, 32'd9, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e || l !== LAT + 1) begin
            failures++;
            $display("FAIL fl_repeat got %h lat=%0d want %h lat=%0d",
                     r, l, e, LAT + 1);
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] r, e;
        int l;
        bit t;
        exp_q.push_back(32'hFFFF_FFFE);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e) begin
            failures++;
            $display("FAIL rm_prime got %h want %h", r, e);
        end
        @(negedge clk);
        req_valid = 1'b1;
        op = 2'b01;
        rs1 = 32'd3;
        rs2 = 32'hFFFF_FFFB;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0
            || result !== 32'd0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin
            failures++;
            $display("FAIL rm_state got rr=%b rv=%b busy=%b res=%h a=%h b=%h",
                     req_ready, resp_valid, busy, result, mul_a, mul_b);
        end
        exp_q.push_back(32'hFFFF_FFFE);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l, t);
        e = exp_q.pop_front();
        checks++;
        if (t || r !== e || l !== LAT + 1) begin
            failures++;
            $display("FAIL rm_after got %h lat=%0d want %h lat=%0d",
                     r, l, e, LAT + 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool[4];
        logic [31:0] r, e, a, b;
        logic [1:0] o;
        int l;
        bit t;
        pool[0] = 32'h8000_0000;
        pool[1] = 32'hFFFF_FFFF;
        pool[2] = 32'h0001_2345;
        pool[3] = 32'hDEAD_BEEF;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pool[$urandom_range(0, 3)];
            b = pool[$urandom_range(0, 3)];
            exp_q.push_back(model(o, a, b));
            run_op(o, a, b, r, l, t);
            e = exp_q.pop_front();
            checks++;
            if (t || r !== e || (l !== 1 && l !== LAT + 1)) begin
                failures++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got %h lat=%0d want %h",
                         i, o, a, b, r, l, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mulh_cache();
        test_classes();
        test_corners();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32M multiply group (MUL, MULH, MULHSU, MULHU) in the single-cycle core's execute stage.
- Accepts one request at a time and converts signed operands to magnitudes.
- Holds operands stable for a fixed number of cycles while the shared combinational 32x32 unsigned multiplier settles, then sign-corrects the 64-bit product and returns the selected half.
- Caches the last product so a MULH[S][U]/MUL pair on identical operands completes in one cycle.

Parameters:
- LAT, 2, cycles spent in CALC before the product is sampled; legal range 1..15.
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- rs1  in  32  multiplicand
- rs2  in  32  multiplier
- flush  in  1  abort in-flight op and invalidate cache
- mul_a  out  32  magnitude operand A to multiplier
- mul_b  out  32  magnitude operand B to multiplier
- mul_p  in  64  unsigned product from multiplier (combinational from mul_a/mul_b)
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer takes result
- result  out  32  selected product half
- busy  out  1  stall request to core: high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, req_ready=1, resp_valid=0, busy=0, result=0, mul_a=0, mul_b=0, cnt=0, cache_valid=0. rst has priority over flush and all handshakes. Reset mid-operation drops the op with no response.
- FSM states: IDLE, CALC, RESP.
- req_ready=1 only in IDLE.
- Accept occurs when req_valid && req_ready && !flush.
- Sign rules:
  - a_neg = rs1[31] for MULH/MULHSU.
  - b_neg = rs2[31] for MULH only.
  - mul_a = a_neg ? -rs1 : rs1; mul_b = b_neg ? -rs2 : rs2 (32-bit two's complement; 0x80000000 maps to itself, correct as unsigned 2^31).
  - Registered neg = a_neg ^ b_neg.
- Cache:
  - Stores rs1, rs2, sign class (op[1:0] of last computed op), and the sign-corrected 64-bit product.
  - Hit: cache_valid && rs1/rs2 equal && (op==MUL || op==cached op, or cached op==MUL with identical class signature for high half — high-half hit requires exact op match).
  - MUL hits on any cached class because the low word is sign-independent.
- IDLE + accept + hit: state->RESP next edge, result=selected half from cache. Latency 1 cycle, multiplier operands not updated.
- IDLE + accept + miss: register mul_a, mul_b, neg, op, rs1, rs2; cnt=LAT-1; state->CALC.
- CALC: cnt decrements each cycle. When cnt==0:
  - prod = neg ? -mul_p : mul_p (64-bit).
  - result = op==MUL ? prod[31:0] : prod[63:32].
  - Cache updated, cache_valid=1, state->RESP.
  - Miss latency: accept edge to resp_valid = LAT+1 cycles.
- RESP: resp_valid=1, result held stable until resp_ready. On resp_valid && resp_ready, state->IDLE (req_ready=1 the following cycle; no same-cycle accept).
- flush: in CALC -> IDLE next edge, no response. In RESP -> drop response, IDLE. Always clears cache_valid. Flush in IDLE blocks acceptance that cycle.
- mul_a/mul_b hold their last value outside CALC; the multiplier may toggle freely.

Test Plan:
- MULH rs1=0xFFFFFFFF rs2=0xFFFFFFFF, LAT=2 -> resp_valid 3 cycles after accept, result=0x00000000. Then MUL same operands -> cache hit, resp 1 cycle after accept, result=0x00000001.
- MULHU rs1=0xFFFFFFFF rs2=0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU same operands -> miss (class differs), result=0xFFFFFFFF.
- MULH rs1=0x80000000 rs2=0x80000000 -> result=0x40000000. MUL rs1=0x00000007 rs2=0xFFFFFFFD -> result=0xFFFFFFEB.
- Back-pressure: resp_ready=0 for 5 cycles in RESP -> resp_valid and result stable, busy=1, req_ready=0. resp_ready=1 -> IDLE next edge.
- flush asserted on the first CALC cycle -> no resp_valid, state IDLE, and a repeat of the same op misses (full LAT+1 latency).
- rst pulsed mid-CALC -> all outputs at reset values next edge. The next request completes normally with correct result.
